// File: rtl/bi_tx_stage_if.sv
// Handshake, coded-bus and statistics signals of the bus-invert transmit stage.
// The producer/link side uses master; the stage itself uses slave.
interface bi_tx_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  bus_data;
  logic        bus_inv;
  logic        stat_clr;
  logic [15:0] raw_toggles;
  logic [15:0] coded_toggles;

  modport master (
    output in_valid, in_data, out_ready, stat_clr,
    input  in_ready, out_valid, bus_data, bus_inv, raw_toggles, coded_toggles
  );

  modport slave (
    input  in_valid, in_data, out_ready, stat_clr,
    output in_ready, out_valid, bus_data, bus_inv, raw_toggles, coded_toggles
  );
endinterface

// File: rtl/bi_tx_stage.sv
// Bus-invert transmit stage: 2-entry FIFO feeding a registered, bus-invert coded
// output word, with saturating toggle statistics for raw and coded traffic.
module bi_tx_stage (
  input  logic          clk,
  input  logic          rst_n,
  bi_tx_stage_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {12'd0, b};
    if (s[16]) begin
      return 16'hFFFF;
    end else begin
      return s[15:0];
    end
  endfunction

  logic [7:0]  mem_r [2];
  logic        wr_ptr_r;
  logic        rd_ptr_r;
  logic [1:0]  count_r;
  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  bus_data_r;
  logic        bus_inv_r;
  logic [7:0]  prev_raw_r;
  logic [15:0] raw_r;
  logic [15:0] coded_r;

  logic        full_s;
  logic        empty_s;
  logic        push_s;
  logic        load_s;
  logic [7:0]  head_s;
  logic [7:0]  enc_data_s;
  logic        enc_inv_s;
  logic [3:0]  raw_inc_s;
  logic [4:0]  coded_inc_s;

  assign full_s  = (count_r == 2'd2);
  assign empty_s = (count_r == 2'd0);
  // A full FIFO refuses a word even when a pop happens in the same cycle.
  assign push_s  = bus.in_valid && !full_s;
  assign head_s  = mem_r[rd_ptr_r];

  assign bus.in_ready      = !full_s;
  assign bus.out_valid     = (state_r == ST_VALID);
  assign bus.bus_data      = bus_data_r;
  assign bus.bus_inv       = bus_inv_r;
  assign bus.raw_toggles   = raw_r;
  assign bus.coded_toggles = coded_r;

  // Output FSM next state and load decision.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          load_s      = 1'b1;
          state_nxt_s = ST_VALID;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_VALID: begin
        if (bus.out_ready && !empty_s) begin
          load_s      = 1'b1;
          state_nxt_s = ST_VALID;
        end else if (bus.out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_VALID;
        end
      end
      default: begin
        load_s      = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Bus-invert encoding of the FIFO head against the word currently on the bus.
  always_comb begin
    enc_data_s = head_s;
    enc_inv_s  = 1'b0;
    if (popcount8(head_s ^ bus_data_r) > 4'd4) begin
      enc_data_s = ~head_s;
      enc_inv_s  = 1'b1;
    end else begin
      enc_data_s = head_s;
      enc_inv_s  = 1'b0;
    end
    raw_inc_s   = popcount8(head_s ^ prev_raw_r);
    coded_inc_s = {1'b0, popcount8(enc_data_s ^ bus_data_r)} + {4'd0, enc_inv_s ^ bus_inv_r};
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= 8'h00;
      mem_r[1] <= 8'h00;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= bus.in_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (load_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, load_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Coded bus word; it is also the reference for the next encode, so it persists through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_data_r <= 8'h00;
      bus_inv_r  <= 1'b0;
      prev_raw_r <= 8'h00;
    end else if (load_s) begin
      bus_data_r <= enc_data_s;
      bus_inv_r  <= enc_inv_s;
      prev_raw_r <= head_s;
    end
  end

  // Saturating toggle statistics; a clear coinciding with a load keeps that load's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_r   <= 16'h0000;
      coded_r <= 16'h0000;
    end else if (bus.stat_clr) begin
      raw_r   <= load_s ? {12'd0, raw_inc_s} : 16'h0000;
      coded_r <= load_s ? {11'd0, coded_inc_s} : 16'h0000;
    end else if (load_s) begin
      raw_r   <= sat_add16(raw_r, {1'b0, raw_inc_s});
      coded_r <= sat_add16(coded_r, coded_inc_s);
    end
  end

endmodule

// File: tb/tb_bi_tx_stage.sv
// Self-checking bench for bi_tx_stage: directed scenarios plus random traffic
// checked against a transaction-level model of the bus-invert stream.
module tb_bi_tx_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bi_tx_stage_if bif ();

  bi_tx_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] q[$];
  logic [7:0] m_bus;
  logic [7:0] m_prev;
  logic       m_inv;
  int         m_raw;
  int         m_coded;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_bus   = 8'h00;
    m_prev  = 8'h00;
    m_inv   = 1'b0;
    m_raw   = 0;
    m_coded = 0;
  endtask

  // A word leaves the stage: it must be the oldest accepted word, coded against the previous bus word.
  task automatic consume();
    logic [7:0] w;
    logic [7:0] eb;
    logic       ei;
    check("word_expected", (q.size() > 0), 1);
    if (q.size() > 0) begin
      w = q.pop_front();
      if ($countones(w ^ m_bus) > 4) begin
        eb = ~w;
        ei = 1'b1;
      end else begin
        eb = w;
        ei = 1'b0;
      end
      m_raw   = sat16(m_raw + $countones(w ^ m_prev));
      m_coded = sat16(m_coded + $countones(eb ^ m_bus) + ((ei != m_inv) ? 1 : 0));
      m_bus   = eb;
      m_inv   = ei;
      m_prev  = w;
      check("bus_data", bif.bus_data, eb);
      check("bus_inv", bif.bus_inv, ei);
      check("raw_toggles", bif.raw_toggles, m_raw);
      check("coded_toggles", bif.coded_toggles, m_coded);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
    bif.in_valid  = v;
    bif.in_data   = d;
    bif.out_ready = rdy;
    bif.stat_clr  = clr;
    @(negedge clk);
    if (bif.out_valid && bif.out_ready) consume();
    if (bif.in_valid && bif.in_ready) q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bif.in_valid  = 1'b0;
    bif.in_data   = 8'h00;
    bif.out_ready = 1'b0;
    bif.stat_clr  = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", bif.out_valid, 0);
    check("rst_in_ready", bif.in_ready, 1);
    check("rst_bus_data", bif.bus_data, 0);
    check("rst_bus_inv", bif.bus_inv, 0);
    check("rst_raw", bif.raw_toggles, 0);
    check("rst_coded", bif.coded_toggles, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // 0xFF after reset inverts; latency is exactly one cycle.
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    check("lat_not_yet", bif.out_valid, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("lat_valid", bif.out_valid, 1);
    check("ff_bus", bif.bus_data, 8'h00);
    check("ff_inv", bif.bus_inv, 1);
    check("ff_raw", bif.raw_toggles, 8);
    check("ff_coded", bif.coded_toggles, 1);
    // 0x0F is a distance-4 tie: sent uninverted.
    step(1'b1, 8'h0F, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("tie_bus", bif.bus_data, 8'h0F);
    check("tie_inv", bif.bus_inv, 0);
    check("tie_raw", bif.raw_toggles, 12);
    check("tie_coded", bif.coded_toggles, 6);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Backpressure: bus holds, FIFO fills, then drains in order one per cycle.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    check("full_in_ready", bif.in_ready, 0);
    check("hold_bus", bif.bus_data, 8'h11);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    check("hold_bus2", bif.bus_data, 8'h11);
    check("hold_inv2", bif.bus_inv, 0);
    for (int i = 0; i < 3; i++) begin
      check("drain_valid", bif.out_valid, 1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drain_idle", bif.out_valid, 0);
    check("drain_empty", q.size(), 0);

    // Statistics clear coinciding with a load of 0xF0 after bus/prev both 0x00.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_clr_raw", bif.raw_toggles, 16);
    step(1'b1, 8'hF0, 1'b1, 1'b0);
    m_raw   = 0;
    m_coded = 0;
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check("clr_load_raw", bif.raw_toggles, 4);
    check("clr_load_coded", bif.coded_toggles, 4);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    m_raw   = 0;
    m_coded = 0;
    check("clr_only_raw", bif.raw_toggles, 0);
    check("clr_only_coded", bif.coded_toggles, 0);

    // Reset while full with a valid word on the bus.
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    check("pre_rst_full", bif.in_ready, 0);
    check("pre_rst_valid", bif.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bif.out_valid, 0);
    check("mid_rst_ready", bif.in_ready, 1);
    check("mid_rst_bus", bif.bus_data, 0);
    check("mid_rst_inv", bif.bus_inv, 0);
    check("mid_rst_raw", bif.raw_toggles, 0);
    check("mid_rst_coded", bif.coded_toggles, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("post_rst_valid", bif.out_valid, 0);
      check("post_rst_ready", bif.in_ready, 1);
    end

    // Saturation: 8200 alternating words overflow raw_toggles.
    for (int i = 0; i < 8200; i++) begin
      step(1'b1, (i % 2 == 1) ? 8'hFF : 8'h00, 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("sat_raw", bif.raw_toggles, 16'hFFFF);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    m_raw   = 0;
    m_coded = 0;
    check("sat_clr_raw", bif.raw_toggles, 0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("final_drained", q.size(), 0);
    check("final_idle", bif.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
